crc_append: RTL

//  Serial USB CRC generator/appender in the TX bit path, directly upstream of the bit stuffer.

---
 rtl/crc_append.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/crc_append.sv
// crc_append: serial USB CRC5/CRC16 generator and appender feeding the bit stuffer.
// Define PID_CHECK_EN to add the pid_err output (PID check-nibble mismatch flag).
module crc_append #(
  parameter int PID_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bstr_in,
  input  logic       bstr_in_ready,
  input  logic       pkt_start,
  input  logic       pkt_end,
  input  logic [1:0] crc_type,
  input  logic       stall_in,
  output logic       stall_out,
  output logic       bstr_out,
  output logic       bstr_out_ready,
  output logic       busy
`ifdef PID_CHECK_EN
  ,
  output logic       pid_err
`endif
);

  localparam int MAX_CNT = (PID_BITS > 16) ? PID_BITS : 16;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(PID_BITS);
  localparam logic [CNT_W-1:0] LEN_CRC5  = CNT_W'(5);
  localparam logic [CNT_W-1:0] LEN_CRC16 = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PID     = 2'd1,
    DATA    = 2'd2,
    CRC_OUT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      crc, crc_nxt;
  logic [1:0]       ctype, ctype_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic             out_bit, out_bit_nxt;
  logic             out_rdy, out_rdy_nxt;
  logic             busy_nxt;
  logic             accept;
  logic             crc_msb;

  // CRC5 lives in crc[4:0]; upper bits are kept zero so the register compares cleanly.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b,
                                           input logic [1:0] t);
    logic [15:0] r;
    logic        fb;
    r  = c;
    fb = 1'b0;
    case (t)
      2'b01: begin
        fb = b ^ c[4];
        r  = {11'd0, c[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
      end
      2'b10: begin
        fb = b ^ c[15];
        r  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic logic has_crc(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  assign stall_out      = stall_in | (state == CRC_OUT);
  assign accept         = bstr_in_ready & ~stall_out;
  assign crc_msb        = (ctype == 2'b01) ? crc[4] : crc[15];
  assign bstr_out       = out_bit;
  assign bstr_out_ready = out_rdy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      crc     <= 16'hFFFF;
      ctype   <= 2'b00;
      bit_cnt <= '0;
      out_bit <= 1'b0;
      out_rdy <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      crc     <= crc_nxt;
      ctype   <= ctype_nxt;
      bit_cnt <= cnt_nxt;
      out_bit <= out_bit_nxt;
      out_rdy <= out_rdy_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    crc_nxt     = crc;
    ctype_nxt   = ctype;
    cnt_nxt     = bit_cnt;
    out_bit_nxt = out_bit;
    out_rdy_nxt = out_rdy;
    if (!stall_in) begin
      out_rdy_nxt = 1'b0;
      if (state == CRC_OUT) begin
        // bit_cnt counts down the remaining CRC bits
        out_bit_nxt = ~crc_msb;
        out_rdy_nxt = 1'b1;
        crc_nxt     = {crc[14:0], 1'b0};
        cnt_nxt     = bit_cnt - CNT_ONE;
        if (bit_cnt == CNT_ONE) begin
          state_nxt = IDLE;
        end
      end else if (accept) begin
        out_bit_nxt = bstr_in;
        out_rdy_nxt = 1'b1;
        if (pkt_start) begin
          ctype_nxt = crc_type;
          crc_nxt   = (crc_type == 2'b01) ? 16'h001F : 16'hFFFF;
          cnt_nxt   = CNT_ONE;
          state_nxt = (PID_BITS <= 1) ? DATA : PID;
        end else if (state == PID) begin
          cnt_nxt = bit_cnt + CNT_ONE;
          if (cnt_nxt == PID_LAST) begin
            state_nxt = DATA;
          end
        end else if (state == DATA) begin
          crc_nxt = crc_step(crc, bstr_in, ctype);
        end
        // pkt_end only matters inside a packet, including one starting on this bit
        if (pkt_end && (state_nxt != IDLE)) begin
          if (has_crc(ctype_nxt)) begin
            state_nxt = CRC_OUT;
            cnt_nxt   = (ctype_nxt == 2'b01) ? LEN_CRC5 : LEN_CRC16;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    end
    // busy stays up while the final bit of a packet is still on bstr_out
    busy_nxt = stall_in ? busy : ((state != IDLE) || (state_nxt != IDLE));
  end

`ifdef PID_CHECK_EN
  logic [7:0] pid_sr, pid_full;
  logic       pid_shift, pid_last, pid_bad;

  assign pid_full  = {bstr_in, pid_sr[7:1]};
  assign pid_shift = accept & (pkt_start | (state == PID));
  assign pid_last  = accept & ~pkt_start & (state == PID) & ((bit_cnt + CNT_ONE) == PID_LAST);
  assign pid_bad   = (pid_full[7:4] != ~pid_full[3:0]);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pid_sr  <= 8'h00;
      pid_err <= 1'b0;
    end else begin
      if (pid_shift) begin
        pid_sr <= pid_full;
      end
      if (accept && pkt_start) begin
        pid_err <= 1'b0;
      end else if (pid_last && pid_bad) begin
        pid_err <= 1'b1;
      end
    end
  end
`endif

endmodule
